// File: rtl/idft_seq_pkg.sv
// Shared types and default register map for the IDFT wishbone sequencer.
package idft_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_ACC,
    ST_LD_WR,
    ST_START,
    ST_POLL,
    ST_RD,
    ST_OUT,
    ST_ERR
  } state_e;

  localparam int          N_POINTS_DEF    = 64;
  localparam int          ACK_TIMEOUT_DEF = 255;
  localparam logic [31:0] IN_BASE_DEF     = 32'h0000_0000;
  localparam logic [31:0] OUT_BASE_DEF    = 32'h0000_0100;
  localparam logic [31:0] CTRL_ADDR_DEF   = 32'h0000_0200;
  localparam logic [31:0] STAT_ADDR_DEF   = 32'h0000_0204;
  localparam logic [31:0] CTRL_START      = 32'h0000_0001;

endpackage

// File: rtl/idft_wb_sequencer_if.sv
// Wishbone-classic bus between the sequencer (master) and the IDFT core (slave).
interface idft_wb_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat_w;
  logic [31:0]       dat_r;
  logic [3:0]        sel;
  logic              we;
  logic              cyc;
  logic              stb;
  logic              ack;

  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/idft_seq_wb_master.sv
// Single-transfer wishbone engine: launches one registered cycle per request and
// reports completion (ack) or abort after ACK_TIMEOUT cycles without ack.
module idft_seq_wb_master #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [31:0]       wdat_i,
  output logic              done_o,
  output logic [31:0]       rdat_o,
  output logic              timeout_o,
  idft_wb_sequencer_if.master wb
);

  logic              cyc_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic [15:0]       tmo_q;
  logic              tmo_hit;

  // An ack on the final allowed cycle still completes the transfer.
  assign tmo_hit = cyc_q & ~wb.ack & (tmo_q == 16'(ACK_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      tmo_q <= '0;
    end else if (!cyc_q) begin
      if (req_i) begin
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= wdat_i;
        tmo_q <= '0;
      end
    end else if (wb.ack || tmo_hit) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      tmo_q <= tmo_q + 16'd1;
    end
  end

  assign wb.cyc    = cyc_q;
  assign wb.stb    = cyc_q;
  assign wb.sel    = {4{cyc_q}};
  assign wb.we     = we_q;
  assign wb.adr    = adr_q;
  assign wb.dat_w  = dat_q;
  assign done_o    = cyc_q & wb.ack;
  assign rdat_o    = wb.dat_r;
  assign timeout_o = tmo_hit;

endmodule

// File: rtl/idft_wb_sequencer.sv
// Frame sequencer for one IDFT core: load N_POINTS samples, start, poll done,
// then stream N_POINTS results out, all over a single wishbone master port.
module idft_wb_sequencer
  import idft_seq_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          N_POINTS    = N_POINTS_DEF,
  parameter logic [31:0] IN_BASE     = IN_BASE_DEF,
  parameter logic [31:0] OUT_BASE    = OUT_BASE_DEF,
  parameter logic [31:0] CTRL_ADDR   = CTRL_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR   = STAT_ADDR_DEF,
  parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        clear_err_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_data_o,
  output logic        m_last_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] frame_cnt_o,
  idft_wb_sequencer_if.master wbm
);

  localparam int               IDX_W    = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       frame_q, frame_d;
  logic              err_q, err_d;

  logic              req, we, done, timeout;
  logic [ADDR_W-1:0] adr, idx_off;
  logic [31:0]       wdat, rdat;
  logic              idx_is_last;

  assign idx_off     = ADDR_W'({idx_q, 2'b00});
  assign idx_is_last = (idx_q == IDX_LAST);

  idft_seq_wb_master #(
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_wb_master (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .we_i      (we),
    .adr_i     (adr),
    .wdat_i    (wdat),
    .done_o    (done),
    .rdat_o    (rdat),
    .timeout_o (timeout),
    .wb        (wbm)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      frame_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    frame_d = frame_q;
    err_d   = err_q;
    req     = 1'b0;
    we      = 1'b0;
    adr     = '0;
    wdat    = '0;

    unique case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_LD_ACC;
      ST_LD_ACC: begin
        if (s_valid_i) begin
          data_d  = s_data_i;
          state_d = ST_LD_WR;
        end
      end
      ST_LD_WR: begin
        req  = 1'b1;
        we   = 1'b1;
        adr  = ADDR_W'(IN_BASE) + idx_off;
        wdat = data_q;
        if (done) begin
          idx_d   = idx_is_last ? '0 : idx_q + 1'b1;
          state_d = idx_is_last ? ST_START : ST_LD_ACC;
        end
      end
      ST_START: begin
        req  = 1'b1;
        we   = 1'b1;
        adr  = ADDR_W'(CTRL_ADDR);
        wdat = CTRL_START;
        if (done) state_d = ST_POLL;
      end
      ST_POLL: begin
        // Not-done reads fall back to an idle bus for a cycle before reissuing.
        req = 1'b1;
        adr = ADDR_W'(STAT_ADDR);
        if (done && rdat[0]) state_d = ST_RD;
      end
      ST_RD: begin
        req = 1'b1;
        adr = ADDR_W'(OUT_BASE) + idx_off;
        if (done) begin
          data_d  = rdat;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready_i) begin
          if (idx_is_last) begin
            idx_d   = '0;
            frame_d = frame_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RD;
          end
        end
      end
      ST_ERR: begin
        if (clear_err_i) begin
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      state_d = ST_ERR;
    end
  end

  assign s_ready_o   = (state_q == ST_LD_ACC);
  assign m_valid_o   = (state_q == ST_OUT);
  assign m_data_o    = data_q;
  assign m_last_o    = (state_q == ST_OUT) && idx_is_last;
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign err_o       = err_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_idft_wb_sequencer.sv
// Scoreboard bench for idft_wb_sequencer with a 4-point frame and a behavioural
// IDFT-core wishbone slave (1-cycle ack, done on third status poll).
module tb_idft_wb_sequencer;

  localparam int NP  = 4;
  localparam int TMO = 255;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_err = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        err;
  logic [15:0] frame_cnt;

  idft_wb_sequencer_if #(.ADDR_W(32)) wb ();

  idft_wb_sequencer #(
    .ADDR_W      (32),
    .N_POINTS    (NP),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .clear_err_i (clear_err),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .m_last_o    (m_last),
    .busy_o      (busy),
    .err_o       (err),
    .frame_cnt_o (frame_cnt),
    .wbm         (wb)
  );

  always #5 clk = ~clk;

  txn_t        exp_bus[$];
  logic [32:0] exp_out[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cur_frame = 0;
  int          exp_frames = 0;
  int          poll_cnt;
  int          out_seen = 0;
  bit          block_en = 1'b0;
  logic [31:0] block_adr = '0;
  bit          sink_stall = 1'b0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] in_val(int f, int i);
    return {16'(f), 16'(i + 1)};
  endfunction

  function automatic logic [31:0] out_val(int f, int i);
    return 32'(f * 32'h0101_0000 + i * 32'h111 + 32'h5A00);
  endfunction

  // IDFT core model: status done on the third poll after start, results by frame.
  always_comb begin
    wb.dat_r = '0;
    if (wb.adr == 32'h204)
      wb.dat_r = {31'b0, poll_cnt == 2};
    else if (wb.adr >= 32'h100 && wb.adr < 32'h100 + 4 * NP)
      wb.dat_r = out_val(cur_frame, int'((wb.adr - 32'h100) >> 2));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.ack   <= 1'b0;
      poll_cnt <= 0;
    end else begin
      wb.ack <= wb.cyc && wb.stb && !wb.ack && !(block_en && wb.adr == block_adr);
      if (wb.cyc && wb.stb && wb.ack) begin
        check("bus_pending", 96'(exp_bus.size() > 0), 96'd1);
        if (exp_bus.size() > 0) begin
          txn_t t;
          t = exp_bus.pop_front();
          check("bus_txn", {wb.we, wb.adr, wb.we ? wb.dat_w : 32'h0}, {t.we, t.adr, t.dat});
        end
        if (wb.we && wb.adr == 32'h200) poll_cnt <= 0;
        if (!wb.we && wb.adr == 32'h204) poll_cnt <= poll_cnt + 1;
      end
    end
  end

  // Sink: compares each handshake; optionally stalls 10 cycles on the second sample.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid && sink_stall && out_seen == 1) begin
        sink_stall = 1'b0;
        m_ready    = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("hold_valid", m_valid, 1);
          if (exp_out.size() > 0) check("hold_data", m_data, exp_out[0][31:0]);
          check("hold_no_bus", wb.cyc, 0);
        end
        m_ready = 1'b1;
      end
      if (m_valid && m_ready) begin
        check("out_pending", 96'(exp_out.size() > 0), 96'd1);
        if (exp_out.size() > 0) begin
          logic [32:0] e;
          e = exp_out.pop_front();
          check("out_sample", {m_last, m_data}, e);
          out_seen = e[32] ? 0 : out_seen + 1;
        end
      end
    end
  end

  task automatic push_frame(input int f);
    for (int i = 0; i < NP; i++) exp_bus.push_back({1'b1, 32'(4 * i), in_val(f, i)});
    exp_bus.push_back({1'b1, 32'h200, 32'h1});
    for (int i = 0; i < 3; i++) exp_bus.push_back({1'b0, 32'h204, 32'h0});
    for (int i = 0; i < NP; i++) begin
      exp_bus.push_back({1'b0, 32'(32'h100 + 4 * i), 32'h0});
      exp_out.push_back({i == NP - 1, out_val(f, i)});
    end
  endtask

  task automatic send_sample(input logic [31:0] d, input int stall);
    int k;
    repeat (stall) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    k = 0;
    while (!s_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("src_accept", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_frames();
    int k;
    k = 0;
    while (frame_cnt != 16'(exp_frames) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("frame_cnt", frame_cnt, exp_frames);
  endtask

  task automatic run_frame(input int stall, input bit drop_en);
    cur_frame++;
    push_frame(cur_frame);
    for (int i = 0; i < NP; i++) begin
      send_sample(in_val(cur_frame, i), (i == 0) ? 0 : stall);
      if (drop_en && i == 0) enable = 1'b0;
    end
    exp_frames++;
    wait_frames();
    check("bus_drained", exp_bus.size(), 0);
    check("out_drained", exp_out.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;

    repeat (2) @(negedge clk);
    check("rst_cyc", wb.cyc, 0);
    check("rst_stb", wb.stb, 0);
    check("rst_sel", wb.sel, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", {m_last, m_data}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_gated", busy, 0);
    enable = 1'b1;

    // Basic frame, then a frame with a sink stall on sample 2.
    run_frame(0, 1'b0);
    sink_stall = 1'b1;
    run_frame(0, 1'b0);

    // Input write 2 never acked: abort after TMO cycles.
    cur_frame++;
    block_adr = 32'h4;
    block_en  = 1'b1;
    exp_bus.push_back({1'b1, 32'h0, in_val(cur_frame, 0)});
    exp_bus.push_back({1'b1, 32'h4, in_val(cur_frame, 1)});
    send_sample(in_val(cur_frame, 0), 0);
    send_sample(in_val(cur_frame, 1), 0);
    k = 0;
    while (!wb.cyc && k < 100) begin
      @(negedge clk);
      k++;
    end
    cnt = 0;
    while (wb.cyc && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_cycles", cnt, TMO);
    check("tmo_err", err, 1);
    check("tmo_s_ready", s_ready, 0);
    check("tmo_busy", busy, 0);
    check("tmo_unacked", exp_bus.size(), 1);
    repeat (5) @(negedge clk);
    check("err_no_bus", wb.cyc, 0);
    check("err_sticky", err, 1);
    exp_bus.delete();
    block_en  = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clr_err", err, 0);
    check("clr_idle", busy, 0);
    run_frame(0, 1'b0);

    // Slow source, enable dropped after the first sample.
    run_frame(20, 1'b1);
    repeat (30) @(negedge clk);
    check("en_low_busy", busy, 0);
    check("en_low_s_ready", s_ready, 0);
    check("en_low_cyc", wb.cyc, 0);
    enable = 1'b1;

    // Reset while a status poll is on the bus.
    cur_frame++;
    push_frame(cur_frame);
    for (int i = 0; i < NP; i++) send_sample(in_val(cur_frame, i), 0);
    k = 0;
    while (!(wb.cyc && wb.adr == 32'h204) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("poll_seen", {wb.cyc, wb.adr}, {1'b1, 32'h204});
    rst_n = 1'b0;
    #1;
    check("arst_cyc", wb.cyc, 0);
    check("arst_stb", wb.stb, 0);
    check("arst_busy", busy, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    exp_bus.delete();
    exp_out.delete();
    exp_frames = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
